// File: rtl/fft_elastic_stage.sv
// Two-entry elastic register between FFT butterfly stages: a registered output
// bundle plus one skid entry, so ready never depends combinationally on downstream.
module fft_elastic_stage #(
  parameter int N     = 16,
  parameter int LANES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [2*N*LANES-1:0]   in_data,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*N*LANES-1:0]   out_data,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2*N*LANES-1:0]   out_data_q, out_data_d;
  logic [2*N*LANES-1:0]   skid_data_q, skid_data_d;
  logic                   out_last_q, out_last_d;
  logic                   skid_last_q, skid_last_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_data_d = in_data;
          out_last_d = in_last;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          out_data_d = in_data;
          out_last_d = in_last;
        end else if (in_fire) begin
          skid_data_d = in_data;
          skid_last_d = in_last;
          state_d     = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          out_data_d = skid_data_q;
          out_last_d = skid_last_q;
          state_d    = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush overrides everything, including an input accepted this cycle.
    if (flush) begin
      state_d     = EMPTY;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      skid_data_d = '0;
      skid_last_d = 1'b0;
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_fft_elastic_stage.sv
// Directed bench for fft_elastic_stage with N=16, LANES=4 (128-bit bundles).
module tb_fft_elastic_stage;

  localparam int N     = 16;
  localparam int LANES = 4;
  localparam int W     = 2 * N * LANES;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           flush = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     occupancy;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  fft_elastic_stage #(.N(N), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bundle whose lane0 real part is v; other components derived from v.
  function automatic logic [W-1:0] mk(input int v);
    logic [W-1:0] b;
    logic [N-1:0] re;
    b = '0;
    for (int k = 0; k < LANES; k++) begin
      re = N'(v + 16'h0100 * k);
      b[2*k*N +: N]     = re;
      b[(2*k+1)*N +: N] = ~re;
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic v, input logic rdy);
    in_data   = d;
    in_valid  = v;
    out_ready = rdy;
  endtask

  logic [W-1:0] pk;
  int tx, rx;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_occ",       W'(occupancy), W'(0));
    check("rst_out_data",  out_data,      '0);
    check("rst_out_last",  W'(out_last),  W'(0));
    #3 rst_n = 1'b1;
    tick();

    // Streaming at full rate
    for (int i = 1; i <= 5; i++) begin
      send(mk(i), 1'b1, 1'b1);
      tick();
      check($sformatf("stream_lane0r_%0d", i), W'(out_data[N-1:0]), W'(i));
      check($sformatf("stream_data_%0d", i), out_data, mk(i));
      check("stream_valid", W'(out_valid), W'(1));
      check("stream_occ",   W'(occupancy), W'(1));
    end
    send('0, 1'b0, 1'b1);
    tick();
    check("drain_valid", W'(out_valid), W'(0));
    check("drain_occ",   W'(occupancy), W'(0));

    // Backpressure: A held, B into skid, C waits upstream
    send(mk(10), 1'b1, 1'b1);
    tick();
    check("bp_A_loaded", out_data, mk(10));
    send(mk(11), 1'b1, 1'b0);
    tick();
    check("bp_occ_full",  W'(occupancy), W'(2));
    check("bp_in_ready0", W'(in_ready),  W'(0));
    check("bp_A_stall1",  out_data,      mk(10));
    send(mk(12), 1'b1, 1'b0);
    tick();
    check("bp_A_stall2",  out_data,      mk(10));
    check("bp_occ_hold",  W'(occupancy), W'(2));
    tick();
    check("bp_A_stall3",  out_data,      mk(10));
    check("bp_valid_stall", W'(out_valid), W'(1));
    out_ready = 1'b1;
    tick();
    check("bp_B_out",     out_data,      mk(11));
    check("bp_in_ready1", W'(in_ready),  W'(1));
    check("bp_occ_busy",  W'(occupancy), W'(1));
    tick();
    check("bp_C_out",     out_data,      mk(12));
    send('0, 1'b0, 1'b1);
    tick();
    check("bp_empty",     W'(out_valid), W'(0));

    // Full lane packing: lane3 imaginary at [127:112]
    pk = mk(20);
    pk[7*N +: N] = 16'h8001;
    send(pk, 1'b1, 1'b1);
    tick();
    check("pack_lane3_i", W'(out_data[127:112]), W'(16'h8001));
    check("pack_full",    out_data, pk);
    send('0, 1'b0, 1'b1);
    tick();

    // Flush while FULL with a bundle offered
    send(mk(30), 1'b1, 1'b1);
    tick();
    send(mk(31), 1'b1, 1'b0);
    tick();
    check("fl_occ_full", W'(occupancy), W'(2));
    send(mk(32), 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid",    W'(out_valid), W'(0));
    check("fl_occ",      W'(occupancy), W'(0));
    check("fl_in_ready", W'(in_ready),  W'(1));
    check("fl_data",     out_data,      '0);
    send('0, 1'b0, 1'b1);
    tick();
    check("fl_no_ghost", W'(out_valid), W'(0));
    // Flush in BUSY while in_fire: the offered bundle is discarded
    send(mk(33), 1'b1, 1'b1);
    tick();
    send(mk(34), 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send('0, 1'b0, 1'b1);
    check("fl_busy_valid", W'(out_valid), W'(0));
    tick();
    check("fl_busy_ghost", W'(out_valid), W'(0));

    // Asynchronous reset between edges while FULL
    send(mk(40), 1'b1, 1'b1);
    tick();
    send(mk(41), 1'b1, 1'b0);
    tick();
    check("ar_occ_full", W'(occupancy), W'(2));
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",    W'(out_valid), W'(0));
    check("ar_data",     out_data,      '0);
    check("ar_occ",      W'(occupancy), W'(0));
    check("ar_in_ready", W'(in_ready),  W'(1));
    #2 rst_n = 1'b1;
    send(mk(50), 1'b1, 1'b1);
    tick();
    check("ar_X_out",   out_data,      mk(50));
    check("ar_X_valid", W'(out_valid), W'(1));
    send('0, 1'b0, 1'b1);
    tick();

    // Last flag on the 32nd bundle under random backpressure
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 600 && rx < 32; cyc++) begin
      in_valid  = (tx < 32);
      in_data   = mk(100 + tx);
      in_last   = (tx == 31);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) begin
        check($sformatf("last_data_%0d", rx), out_data, mk(100 + rx));
        check($sformatf("last_flag_%0d", rx), W'(out_last), W'(rx == 31));
        rx++;
      end
      if (in_valid && in_ready) tx++;
      tick();
    end
    check("last_count", W'(rx), W'(32));
    in_valid = 1'b0;
    in_last  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/fft_elastic_stage.md
Name: fft_elastic_stage

Overview:
- Parametrised successor to the fixed 32-lane pipeline register used between FFT butterfly stages.
- Registers a bundle of LANES complex samples, each N bits per component, with a valid/ready handshake and a 2-entry skid buffer.
- Upstream and downstream stages can stall independently, with no bubbles and no combinational ready path.
- Adds a frame-last sideband, a synchronous flush and an occupancy output.
- Sits between any two butterfly stages, or between the last stage and the output reorder logic.

Parameters:
- N, 16, bit width of each real or imaginary component.
- LANES, 32, complex samples per bundle (≥1).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous clear of all buffered data (active-high).
- in_data, input, 2*N*LANES, packed bundle. Lane k real part is at [2kN +: N]; lane k imaginary part is at [(2k+1)N +: N].
- in_last, input, 1, marks the final bundle of an FFT frame; travels with in_data.
- in_valid, input, 1, upstream bundle valid.
- in_ready, output, 1, stage can accept a bundle. Registered.
- out_data, output, 2*N*LANES, registered bundle, same packing as in_data.
- out_last, output, 1, last flag aligned with out_data.
- out_valid, output, 1, out_data holds a valid bundle.
- out_ready, input, 1, downstream accepts.
- occupancy, output, 2, bundles held (0..2).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_data=0, out_last=0, out_valid=0.
  - Skid data and skid last cleared to 0.
  - in_ready=1, occupancy=0, state=EMPTY.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data and last are captured only on a fire.
- Latency and throughput:
  - Latency is 1 cycle from in_fire to out_valid when the stage is empty.
  - Sustained throughput is 1 bundle/cycle while out_ready=1.
- State machine (occupancy = 0/1/2):
  - EMPTY:
    - in_fire -> load out reg, go to BUSY.
    - Otherwise stay.
  - BUSY:
    - in_fire & out_fire -> load out reg, stay BUSY.
    - in_fire & !out_ready -> load skid reg, go to FULL.
    - !in_fire & out_fire -> go to EMPTY.
    - Otherwise hold.
  - FULL:
    - in_ready=0.
    - out_fire -> out reg <= skid reg, go to BUSY.
    - Otherwise hold.
- in_ready is registered, equals (state != FULL) for the next cycle, and never depends combinationally on out_ready.
- out_data and out_last are stable while out_valid=1 and out_ready=0. Required by the downstream butterfly stage.
- Bundle order is strictly FIFO; no bundle is dropped or duplicated.
- Flush:
  - Synchronous and highest priority.
  - Next state is EMPTY. out_valid=0, in_ready=1, occupancy=0, data and last registers cleared to 0.
  - An in_fire in the flush cycle is discarded.
- Reset asserted mid-transfer:
  - All state is lost immediately and outputs go to their reset values.
  - After deassertion, the first accepted bundle appears at out_data one cycle later.
- No arithmetic is performed; the bundle width is exactly 2*N*LANES with no sign extension.
- Lane packing is identical on input and output.

Test Plan:
- Streaming: out_ready=1; drive bundles with lane0_r = 1,2,3,... every cycle -> out_data lane0_r = 1,2,3,... one cycle later, out_valid continuous, occupancy=1.
- Backpressure: with BUSY holding A, drop out_ready for 3 cycles while sending B, C.
  - B is accepted into skid; in_ready=0 the next cycle; C is held upstream; occupancy=2.
  - On release, outputs are A, B, C in order with A stable throughout the stall.
- Full packing: N=16, LANES=4; lane3_i=16'h8001 -> out_data[127:112]=16'h8001, all other lanes intact.
- Flush: FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the flushed-cycle bundle never appears.
- Reset mid-operation: assert rst_n=0 asynchronously between edges while FULL -> out_valid=0 and out_data=0 immediately. After release, first bundle X appears one cycle after acceptance.
- Last flag: in_last=1 on the 32nd bundle under random out_ready -> out_last=1 only with the 32nd output bundle.
